synapse_accumulator: RTL

- Fully-connected synaptic layer placed directly upstream of the lif neuron array.
- Takes a binary input spike vector once per timestep and computes, for every output neuron j, current[j] = sum over i of (spike[i] ? W[j][i] : 0), plus an optional bias.
- Time-multiplexes a single accumulator and saturates each result to QS2.13.
- Outputs a current vector plus a one-cycle done pulse; the pulse drives the lif array's enable directly.

---
 rtl/snn_pkg.sv | 29 ++
 rtl/synapse_accumulator_if.sv | 27 ++
 rtl/synapse_weight_mem.sv | 69 ++++++
 rtl/synapse_accumulator.sv | 131 +++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared QS2.13 fixed-point definitions for the spiking datapath:
// number-format constants, the sample type, FSM state codes and saturation.
package snn_pkg;

  localparam int FRAC_BITS = 13;
  localparam int ONE       = 8192;
  localparam int Q_MAX     = 32767;
  localparam int Q_MIN     = -32768;

  typedef logic signed [15:0] q2_13_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_STORE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Clamp a wide signed accumulator value into the QS2.13 range.
  function automatic q2_13_t sat16(input logic signed [63:0] v);
    if (v > 64'(Q_MAX)) begin
      return q2_13_t'(Q_MAX);
    end else if (v < 64'(Q_MIN)) begin
      return q2_13_t'(Q_MIN);
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/synapse_accumulator_if.sv
// Control, weight-write and result bus between the synapse accumulator and
// its host; the master side drives requests, the slave side returns currents.
interface synapse_accumulator_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 16
);
  localparam int ADDR_W = $clog2(NUM_OUTPUTS*(NUM_INPUTS+1));

  logic                          start;
  logic [NUM_INPUTS-1:0]         in_spikes;
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic signed [15:0]            wr_data;
  logic                          busy;
  logic                          done;
  logic [NUM_OUTPUTS*16-1:0]     current_out;

  modport master (
    output start, in_spikes, wr_en, wr_addr, wr_data,
    input  busy, done, current_out
  );

  modport slave (
    input  start, in_spikes, wr_en, wr_addr, wr_data,
    output busy, done, current_out
  );
endinterface

// File: rtl/synapse_weight_mem.sv
// Register-array weight store with a combinational (j,i) read port; bias
// storage exists only when SYNAPSE_BIAS_EN is defined, otherwise bias reads 0.
module synapse_weight_mem
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 16,
  parameter int ADDR_W      = 7,
  parameter int J_W         = 4,
  parameter int I_W         = 2
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  q2_13_t            wr_data_i,
  input  logic [J_W-1:0]    rd_j_i,
  input  logic [I_W-1:0]    rd_i_i,
  output q2_13_t            rd_w_o,
  output q2_13_t            rd_b_o
);

  q2_13_t w_q [NUM_OUTPUTS][NUM_INPUTS];

  always_ff @(posedge clk_i) begin
    for (int jj = 0; jj < NUM_OUTPUTS; jj++) begin
      for (int ii = 0; ii < NUM_INPUTS; ii++) begin
        if (wr_en_i && (wr_addr_i == ADDR_W'(jj*NUM_INPUTS + ii))) begin
          w_q[jj][ii] <= wr_data_i;
        end
      end
    end
  end

  always_comb begin
    rd_w_o = '0;
    for (int jj = 0; jj < NUM_OUTPUTS; jj++) begin
      for (int ii = 0; ii < NUM_INPUTS; ii++) begin
        if ((rd_j_i == J_W'(jj)) && (rd_i_i == I_W'(ii))) begin
          rd_w_o = w_q[jj][ii];
        end
      end
    end
  end

`ifdef SYNAPSE_BIAS_EN
  // Biases sit directly above the weight block in the write address map.
  q2_13_t b_q [NUM_OUTPUTS];

  always_ff @(posedge clk_i) begin
    for (int jj = 0; jj < NUM_OUTPUTS; jj++) begin
      if (wr_en_i && (wr_addr_i == ADDR_W'(NUM_OUTPUTS*NUM_INPUTS + jj))) begin
        b_q[jj] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_b_o = '0;
    for (int jj = 0; jj < NUM_OUTPUTS; jj++) begin
      if (rd_j_i == J_W'(jj)) begin
        rd_b_o = b_q[jj];
      end
    end
  end
`else
  assign rd_b_o = '0;
`endif

endmodule

// File: rtl/synapse_accumulator.sv
// Time-multiplexed fully-connected synapse layer: one accumulator walks every
// (output, input) pair per timestep. Optional bias via SYNAPSE_BIAS_EN.
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 16,
  parameter int ACC_W       = 24
) (
  input logic                  clk,
  input logic                  reset,
  synapse_accumulator_if.slave bus
);

  localparam int ADDR_W = $clog2(NUM_OUTPUTS*(NUM_INPUTS+1));
  localparam int J_W    = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int I_W    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [J_W-1:0] J_LAST = J_W'(NUM_OUTPUTS-1);
  localparam logic [I_W-1:0] I_LAST = I_W'(NUM_INPUTS-1);

  state_t                    state_q, state_d;
  logic [J_W-1:0]            j_q, j_d;
  logic [I_W-1:0]            i_q, i_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [NUM_INPUTS-1:0]     spikes_q, spikes_d;
  logic [NUM_OUTPUTS*16-1:0] cur_q, cur_d;

  q2_13_t                    w_rd;
  q2_13_t                    b_rd;
  q2_13_t                    acc_sat;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   term;
  logic                      mem_we;

  // Writes are only honoured while idle so weights stay frozen during a run.
  assign mem_we = bus.wr_en && (state_q == ST_IDLE);

  synapse_weight_mem #(
    .NUM_INPUTS  (NUM_INPUTS),
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .ADDR_W      (ADDR_W),
    .J_W         (J_W),
    .I_W         (I_W)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (mem_we),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_j_i    (j_q),
    .rd_i_i    (i_q),
    .rd_w_o    (w_rd),
    .rd_b_o    (b_rd)
  );

  // The bias is folded in on the first input of each neuron, so a bias
  // written in the same cycle as start is already visible.
  assign acc_base = (i_q == '0) ? {{(ACC_W-16){b_rd[15]}}, b_rd} : acc_q;
  assign term     = spikes_q[i_q] ? {{(ACC_W-16){w_rd[15]}}, w_rd} : '0;
  assign acc_sat  = sat16({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q});

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    i_d      = i_q;
    acc_d    = acc_q;
    spikes_d = spikes_q;
    cur_d    = cur_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          spikes_d = bus.in_spikes;
          j_d      = '0;
          i_d      = '0;
          acc_d    = '0;
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_base + term;
        if (i_q == I_LAST) begin
          state_d = ST_STORE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      ST_STORE: begin
        for (int jj = 0; jj < NUM_OUTPUTS; jj++) begin
          if (j_q == J_W'(jj)) begin
            cur_d[16*jj +: 16] = acc_sat;
          end
        end
        i_d = '0;
        if (j_q == J_LAST) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = ST_ACCUM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      j_q      <= '0;
      i_q      <= '0;
      acc_q    <= '0;
      spikes_q <= '0;
      cur_q    <= '0;
    end else begin
      state_q  <= state_d;
      j_q      <= j_d;
      i_q      <= i_d;
      acc_q    <= acc_d;
      spikes_q <= spikes_d;
      cur_q    <= cur_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.current_out = cur_q;

endmodule
